// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one SRAM controller between two requesters. Port A (GBA bus
// emulation) has priority; port B (Pi host loader/debug) is forced through
// after STARVE_LIMIT consecutive A grants while it waits.
//
// The controller runs a free-running SLOT_CYCLES-long read/write round whose
// phase is unknown to us. We therefore present one access per window and hold
// it stable for the whole window, so the controller samples it exactly once.
//
// Ports:
//   IwClk, IwRstn                 clock, asynchronous active-low reset
//   IwReq*/IwWe*/IbAddr*/IbWData* per-port request (A and B)
//   OwAck*                        one-cycle accept pulse (cnt==0 cycle)
//   OwRValid*/ObRData*            one-cycle read-data pulse, data held
//   ObSram*/OwSramWrite           fields presented to the SRAM controller
//   IbSramRData                   controller read data
//
// Handshake: a requester raises IwReq* with its fields and holds them until
// it sees OwAck*. The arbiter looks at requests only on the load edge (the
// edge ending the last cycle of a window); OwAck* is high for the cnt==0
// cycle that follows. After the ack the requester may drop or change its
// request; it is next looked at on the following load edge. A request that
// is withdrawn before a load edge is simply never granted.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned SLOT_CYCLES  = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              IwClk,
  input  logic              IwRstn,
  input  logic              IwReqA,
  input  logic              IwWeA,
  input  logic [ADDR_W-1:0] IbAddrA,
  input  logic [DATA_W-1:0] IbWDataA,
  output logic              OwAckA,
  output logic              OwRValidA,
  output logic [DATA_W-1:0] ObRDataA,
  input  logic              IwReqB,
  input  logic              IwWeB,
  input  logic [ADDR_W-1:0] IbAddrB,
  input  logic [DATA_W-1:0] IbWDataB,
  output logic              OwAckB,
  output logic              OwRValidB,
  output logic [DATA_W-1:0] ObRDataB,
  output logic [ADDR_W-1:0] ObSramReadAddress,
  output logic [ADDR_W-1:0] ObSramWriteAddress,
  output logic [DATA_W-1:0] ObSramWData,
  output logic              OwSramWrite,
  input  logic [DATA_W-1:0] IbSramRData
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
  // Read data is captured at the edge ending cnt==2 of the window after the
  // access window: late enough for the controller's data at any phase, and
  // early enough that the next access has not replaced it yet.
  localparam logic [CNT_W-1:0] CNT_CAPT = CNT_W'(2);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  // Tag of the access occupying a window; rd==0 means "no read" (idle or write).
  typedef struct packed {
    logic rd;
    logic port;   // 0 = A, 1 = B
  } tag_t;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  tag_t              cur_tag_q, cur_tag_d;
  tag_t              prev_tag_q, prev_tag_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              rvalid_a_q, rvalid_a_d;
  logic              rvalid_b_q, rvalid_b_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic [ADDR_W-1:0] sram_raddr_q, sram_raddr_d;
  logic [ADDR_W-1:0] sram_waddr_q, sram_waddr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic              sram_we_q, sram_we_d;

  logic              load_edge;
  logic              capt_edge;
  logic              force_b;
  logic              grant_a;
  logic              grant_b;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  always_comb begin
    cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    load_edge    = (cnt_q == CNT_LAST);
    capt_edge    = (cnt_q == CNT_CAPT);

    force_b      = IwReqB && (starve_q == STV_MAX);
    grant_a      = IwReqA && !force_b;
    grant_b      = IwReqB && !grant_a;
    win_we       = grant_a ? IwWeA    : IwWeB;
    win_addr     = grant_a ? IbAddrA  : IbAddrB;
    win_wdata    = grant_a ? IbWDataA : IbWDataB;

    starve_d     = starve_q;
    cur_tag_d    = cur_tag_q;
    prev_tag_d   = prev_tag_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    rvalid_a_d   = 1'b0;
    rvalid_b_d   = 1'b0;
    rdata_a_d    = rdata_a_q;
    rdata_b_d    = rdata_b_q;
    sram_raddr_d = sram_raddr_q;
    sram_waddr_d = sram_waddr_q;
    sram_wdata_d = sram_wdata_q;
    sram_we_d    = sram_we_q;

    if (load_edge) begin
      prev_tag_d = cur_tag_q;
      cur_tag_d  = '0;
      sram_we_d  = 1'b0;
      if (grant_a || grant_b) begin
        ack_a_d   = grant_a;
        ack_b_d   = grant_b;
        cur_tag_d = '{rd: !win_we, port: grant_b};
        if (win_we) begin
          sram_waddr_d = win_addr;
          sram_wdata_d = win_wdata;
          sram_we_d    = 1'b1;
        end else begin
          sram_raddr_d = win_addr;
        end
      end
      // Starvation count: consecutive A wins while B is waiting.
      if (!IwReqB || grant_b) begin
        starve_d = '0;
      end else if (grant_a && (starve_q != STV_MAX)) begin
        starve_d = starve_q + 1'b1;
      end
    end

    if (capt_edge && prev_tag_q.rd) begin
      if (prev_tag_q.port) begin
        rdata_b_d  = IbSramRData;
        rvalid_b_d = 1'b1;
      end else begin
        rdata_a_d  = IbSramRData;
        rvalid_a_d = 1'b1;
      end
    end
  end

  always_ff @(posedge IwClk or negedge IwRstn) begin
    if (!IwRstn) begin
      cnt_q        <= '0;
      starve_q     <= '0;
      cur_tag_q    <= '0;
      prev_tag_q   <= '0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
      sram_raddr_q <= '0;
      sram_waddr_q <= '0;
      sram_wdata_q <= '0;
      sram_we_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      cur_tag_q    <= cur_tag_d;
      prev_tag_q   <= prev_tag_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      rvalid_a_q   <= rvalid_a_d;
      rvalid_b_q   <= rvalid_b_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
      sram_raddr_q <= sram_raddr_d;
      sram_waddr_q <= sram_waddr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_we_q    <= sram_we_d;
    end
  end

  assign OwAckA             = ack_a_q;
  assign OwAckB             = ack_b_q;
  assign OwRValidA          = rvalid_a_q;
  assign OwRValidB          = rvalid_b_q;
  assign ObRDataA           = rdata_a_q;
  assign ObRDataB           = rdata_b_q;
  assign ObSramReadAddress  = sram_raddr_q;
  assign ObSramWriteAddress = sram_waddr_q;
  assign ObSramWData        = sram_wdata_q;
  assign OwSramWrite        = sram_we_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: directed vector table plus hand-written
// sequences, with a behavioural SRAM controller running at a selectable phase.
module tb_sram_port_arbiter;

  typedef struct {
    bit          port;   // 0 = A, 1 = B
    bit          we;
    logic [16:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;    // expected read data (reads only)
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rstn;
  logic        req_a, we_a, req_b, we_b;
  logic [16:0] addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b;
  logic        ack_a, rvalid_a, ack_b, rvalid_b;
  logic [15:0] rdata_a, rdata_b;
  logic [16:0] sram_raddr, sram_waddr;
  logic [15:0] sram_wdata;
  logic        sram_write;
  logic [15:0] ctl_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sram_port_arbiter dut (
    .IwClk(clk), .IwRstn(rstn),
    .IwReqA(req_a), .IwWeA(we_a), .IbAddrA(addr_a), .IbWDataA(wdata_a),
    .OwAckA(ack_a), .OwRValidA(rvalid_a), .ObRDataA(rdata_a),
    .IwReqB(req_b), .IwWeB(we_b), .IbAddrB(addr_b), .IbWDataB(wdata_b),
    .OwAckB(ack_b), .OwRValidB(rvalid_b), .ObRDataB(rdata_b),
    .ObSramReadAddress(sram_raddr), .ObSramWriteAddress(sram_waddr),
    .ObSramWData(sram_wdata), .OwSramWrite(sram_write),
    .IbSramRData(ctl_rdata)
  );

  function automatic logic [15:0] pat(input logic [16:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  // ---------------- SRAM controller model ----------------
  // Free-running 5-cycle round; samples the request fields once per round at
  // ctl_cnt==ctl_phase, and presents read data two cycles later.
  logic [15:0] mem [0:131071];
  bit          mem_init = 1'b0;
  int          ctl_cnt = 0;
  int          ctl_phase = 0;
  int          ctl_wr_count = 0;
  logic [16:0] ctl_addr = '0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 131072; i++) mem[i] = pat(17'(i));
      mem_init = 1'b1;
    end
    ctl_cnt <= (ctl_cnt == 4) ? 0 : ctl_cnt + 1;
    if (ctl_cnt == ctl_phase) begin
      if (sram_write) begin
        mem[sram_waddr] = sram_wdata;
        ctl_wr_count <= ctl_wr_count + 1;
      end
      ctl_addr <= sram_raddr;
    end
    if (ctl_cnt == (ctl_phase + 2) % 5) ctl_rdata <= mem[ctl_addr];
  end

  // Window phase as seen by the bench (0 = ack cycle).
  int ph;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) ph <= 0;
    else       ph <= (ph == 4) ? 0 : ph + 1;
  end

  // ---------------- scoreboard state ----------------
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          wr_hi = 0;
  int          a_noise = 0;
  bit          a_quiet = 1'b0;
  vec_t        cmd_q [2][$];
  logic [15:0] exp_q [2][$];
  int          exp_cyc_q [2][$];
  int          ack_cyc_log [2][$];
  bit          grant_log [$];
  vec_t        vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
  endtask

  // ---------------- driver ----------------
  task automatic drive_pins();
    vec_t c;
    if (cmd_q[0].size() > 0) begin
      c = cmd_q[0][0];
      req_a = 1'b1; we_a = c.we; addr_a = c.addr; wdata_a = c.wdata;
    end else begin
      req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    end
    if (cmd_q[1].size() > 0) begin
      c = cmd_q[1][0];
      req_b = 1'b1; we_b = c.we; addr_b = c.addr; wdata_b = c.wdata;
    end else begin
      req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    end
  endtask

  // One clock: sample at the falling edge, score acks/read data, re-drive.
  task automatic tick();
    logic [1:0]  ack;
    logic [1:0]  rv;
    logic [15:0] rd [2];
    logic [15:0] e;
    int          ec;
    vec_t        c;
    string       pn;
    @(negedge clk);
    cyc++;
    ack   = {ack_b, ack_a};
    rv    = {rvalid_b, rvalid_a};
    rd[0] = rdata_a;
    rd[1] = rdata_b;
    if (sram_write) wr_hi++;
    if (a_quiet && (ack_a || rvalid_a || rdata_a != 16'h0)) a_noise++;
    for (int p = 0; p < 2; p++) begin
      pn = (p == 0) ? "a" : "b";
      if (rv[p]) begin
        check({"rvalid_expected_", pn}, exp_q[p].size() > 0, 1);
        if (exp_q[p].size() > 0) begin
          e  = exp_q[p].pop_front();
          ec = exp_cyc_q[p].pop_front();
          check({"rdata_", pn}, rd[p], e);
          check({"read_latency_", pn}, cyc - ec, 8);
        end
      end
      if (ack[p]) begin
        check({"ack_phase_", pn}, ph, 0);
        check({"single_winner_", pn}, ack[1-p], 0);
        grant_log.push_back(p == 1);
        ack_cyc_log[p].push_back(cyc);
        check({"ack_expected_", pn}, cmd_q[p].size() > 0, 1);
        if (cmd_q[p].size() > 0) begin
          c = cmd_q[p].pop_front();
          if (c.we) begin
            check({"sram_we_", pn}, sram_write, 1);
            check({"sram_waddr_", pn}, sram_waddr, c.addr);
            check({"sram_wdata_", pn}, sram_wdata, c.wdata);
          end else begin
            check({"sram_rd_", pn}, sram_write, 0);
            check({"sram_raddr_", pn}, sram_raddr, c.addr);
            exp_q[p].push_back(c.exp);
            exp_cyc_q[p].push_back(cyc);
          end
        end
      end
    end
    drive_pins();
  endtask

  task automatic clear_all();
    for (int p = 0; p < 2; p++) begin
      cmd_q[p].delete();
      exp_q[p].delete();
      exp_cyc_q[p].delete();
      ack_cyc_log[p].delete();
    end
    grant_log.delete();
    drive_pins();
  endtask

  // Called at a falling edge: release reset and restart cycle bookkeeping.
  task automatic release_reset();
    rstn  = 1'b1;
    cyc   = 0;
    wr_hi = 0;
    for (int p = 0; p < 2; p++) ack_cyc_log[p].delete();
    grant_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  task automatic run(input int budget);
    int n = 0;
    drive_pins();
    while ((cmd_q[0].size() + cmd_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
           && n < budget) begin
      tick();
      n++;
    end
    check("drained_in_budget",
          cmd_q[0].size() + cmd_q[1].size() + exp_q[0].size() + exp_q[1].size(), 0);
    repeat (6) tick();
  endtask

  task automatic wait_grant(input int budget);
    int n = 0;
    drive_pins();
    while (grant_log.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    check("grant_seen", grant_log.size() > 0, 1);
  endtask

  // Pull reset mid-cycle and confirm every output clears without a clock edge.
  task automatic async_reset_mid(input string tag);
    #2;
    rstn = 1'b0;
    #1;
    check({tag, "_sram_write"}, sram_write, 0);
    check({tag, "_sram_raddr"}, sram_raddr, 0);
    check({tag, "_sram_waddr"}, sram_waddr, 0);
    check({tag, "_sram_wdata"}, sram_wdata, 0);
    check({tag, "_port_flags"}, {ack_a, rvalid_a, ack_b, rvalid_b}, 0);
    check({tag, "_port_rdata"}, {rdata_a, rdata_b}, 0);
    clear_all();
    @(negedge clk);
    release_reset();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rstn = 1'b0;
    clear_all();

    // Hand-computed vectors: A write/read-back, five back-to-back A reads of
    // preloaded addresses (data = addr ^ 0xA5A5), then a B-only write/read.
    vecs[0] = '{1'b0, 1'b1, 17'h00010, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 17'h00010, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b0, 17'h00001, 16'h0000, 16'hA5A4};
    vecs[3] = '{1'b0, 1'b0, 17'h00002, 16'h0000, 16'hA5A7};
    vecs[4] = '{1'b0, 1'b0, 17'h00003, 16'h0000, 16'hA5A6};
    vecs[5] = '{1'b0, 1'b0, 17'h00004, 16'h0000, 16'hA5A1};
    vecs[6] = '{1'b0, 1'b0, 17'h00005, 16'h0000, 16'hA5A0};
    vecs[7] = '{1'b1, 1'b1, 17'h00020, 16'h5A5A, 16'h0000};
    vecs[8] = '{1'b1, 1'b0, 17'h00020, 16'h0000, 16'h5A5A};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sram_write", sram_write, 0);
    check("rst_sram_raddr", sram_raddr, 0);
    check("rst_sram_waddr", sram_waddr, 0);
    check("rst_sram_wdata", sram_wdata, 0);
    check("rst_ack", {ack_a, ack_b}, 0);
    check("rst_rvalid", {rvalid_a, rvalid_b}, 0);
    check("rst_rdata", {rdata_a, rdata_b}, 0);
    release_reset();

    // A write + read-back + five consecutive reads, all back-to-back windows
    for (int i = 0; i < 7; i++) cmd_q[vecs[i].port].push_back(vecs[i]);
    run(120);
    check("a_ack_count", ack_cyc_log[0].size(), 7);
    for (int i = 0; i < ack_cyc_log[0].size(); i++)
      check("a_ack_cycle", ack_cyc_log[0][i], 5 * (i + 1));
    check("a_write_high_cycles", wr_hi, 5);

    // B only: granted every window, A side silent
    do_reset();
    a_quiet = 1'b1;
    for (int i = 7; i < 9; i++) cmd_q[vecs[i].port].push_back(vecs[i]);
    run(80);
    a_quiet = 1'b0;
    check("b_only_a_quiet", a_noise, 0);
    check("b_ack_count", ack_cyc_log[1].size(), 2);
    for (int i = 0; i < ack_cyc_log[1].size(); i++)
      check("b_ack_cycle", ack_cyc_log[1][i], 5 * (i + 1));

    // Both ports reading continuously: B forced in after four A grants
    do_reset();
    for (int k = 0; k < 12; k++)
      cmd_q[0].push_back('{1'b0, 1'b0, 17'h00100 + 17'(k), 16'h0, pat(17'h00100 + 17'(k))});
    for (int k = 0; k < 3; k++)
      cmd_q[1].push_back('{1'b1, 1'b0, 17'h00200 + 17'(k), 16'h0, pat(17'h00200 + 17'(k))});
    run(200);
    begin
      bit exp_order [10];
      exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      check("ab_grant_count", grant_log.size(), 15);
      for (int i = 0; i < 10 && i < grant_log.size(); i++)
        check("ab_grant_order", grant_log[i], exp_order[i]);
    end

    // Every controller phase: write/read 0x1FFFF. Data varies per phase so a
    // lost write cannot hide behind the previous iteration's value.
    for (int p = 0; p < 5; p++) begin
      int wr0;
      ctl_phase = p;
      do_reset();
      wr0 = ctl_wr_count;
      cmd_q[0].push_back('{1'b0, 1'b1, 17'h1FFFF, 16'h1234 + 16'(p), 16'h0});
      cmd_q[0].push_back('{1'b0, 1'b0, 17'h1FFFF, 16'h0, 16'h1234 + 16'(p)});
      run(80);
      check("phase_write_count", ctl_wr_count - wr0, 1);
      check("phase_write_high", wr_hi, 5);
    end
    ctl_phase = 0;

    // Reset while a write is presented to the controller
    do_reset();
    cmd_q[0].push_back('{1'b0, 1'b1, 17'h00044, 16'h1111, 16'h0});
    wait_grant(20);
    async_reset_mid("rst_wr");

    // Reset while a read is in flight; its response must never appear and
    // the next request is accepted at the first ack slot.
    cmd_q[0].push_back('{1'b0, 1'b0, 17'h00030, 16'h0, 16'hA595});
    wait_grant(20);
    repeat (2) tick();
    async_reset_mid("rst_rd");
    cmd_q[0].push_back('{1'b0, 1'b0, 17'h00031, 16'h0, 16'hA594});
    run(60);
    check("post_reset_ack_count", ack_cyc_log[0].size(), 1);
    if (ack_cyc_log[0].size() > 0)
      check("post_reset_ack_cycle", ack_cyc_log[0][0], 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single SRAM controller between two requesters:
  - Port A: GBA bus emulation, high priority.
  - Port B: Pi host loader/debug, low priority, protected against starvation.
- Feeds the controller's free-running 5-cycle read/write round by holding one request stable for a full window, so the controller samples it exactly once regardless of its phase.
- Returns read data per port.

Parameters:
- ADDR_W, 17, SRAM word address width.
- DATA_W, 16, SRAM data width.
- SLOT_CYCLES, 5, window length; must equal the controller round length.
- STARVE_LIMIT, 4, consecutive A grants while B waits before B is forced.

Ports:
- IwClk  in  1  system clock; all logic on rising edge.
- IwRstn  in  1  asynchronous active-low reset.
- IwReqA  in  1  port A request valid; held with its fields until OwAckA is seen.
- IwWeA  in  1  1 = write, 0 = read.
- IbAddrA  in  ADDR_W  port A word address.
- IbWDataA  in  DATA_W  port A write data.
- OwAckA  out  1  one-cycle pulse: request accepted.
- OwRValidA  out  1  one-cycle pulse: ObRDataA valid.
- ObRDataA  out  DATA_W  read data for port A; held until the next A read.
- IwReqB, IwWeB, IbAddrB, IbWDataB, OwAckB, OwRValidB, ObRDataB: same as port A, for port B.
- ObSramReadAddress  out  ADDR_W  controller read address.
- ObSramWriteAddress  out  ADDR_W  controller write address.
- ObSramWData  out  DATA_W  controller write data.
- OwSramWrite  out  1  controller write strobe.
- IbSramRData  in  DATA_W  controller read data output.

Behaviour:
- Reset (async, IwRstn=0):
  - Window counter = 0.
  - All Ow*/Ob* outputs = 0; OwSramWrite drops immediately.
  - Tags and starvation counter cleared.
  - In-flight read responses are dropped, never delivered.
  - A write already sampled by the controller before reset may still complete; this is accepted.
- Window counter: cnt runs 0..SLOT_CYCLES-1 and wraps, free-running out of reset.
- Load edge (the rising edge ending a cnt==SLOT_CYCLES-1 cycle; first load is the edge ending the first cnt==4 cycle after reset):
  - Arbitrate and load the winner's fields into the Sram outputs.
  - Fields stay stable for the whole following window (cnt 0..4).
  - Read: ObSramReadAddress=addr, OwSramWrite=0; write address and data unchanged.
  - Write: ObSramWriteAddress=addr, ObSramWData=data, OwSramWrite=1; read address unchanged.
  - No winner: OwSramWrite=0, addresses and data hold (idle window).
- Arbitration (sampled only at the load edge):
  - A wins unless B is requesting and starve==STARVE_LIMIT; then B wins.
  - starve increments when A wins while IwReqB=1.
  - starve clears when B wins or IwReqB=0.
  - starve saturates at STARVE_LIMIT.
- Ack: the winner's OwAck is high during cnt==0 only. The requester may drop or change its request after the ack; the next sample is the next load edge. Minimum spacing per port is one request per window.
- Tags:
  - At each load edge: prev_tag <= cur_tag; cur_tag <= {is_read, port} of the winner, or none.
  - Read capture happens at the edge ending cnt==2. This is the 8th edge after that window's load edge, and is valid for any controller phase.
  - At capture, if prev_tag is a read: ObRData(port) <= IbSramRData, and that port's OwRValid is high the next cycle (cnt==3).
- Latency (read): ack cycle to rvalid cycle = 8 cycles, fixed.
- Throughput: one access per 5 cycles total.
- Ordering:
  - Accesses reach SRAM in grant order.
  - A read granted in the window after a write to the same address returns the new data.
  - A read and write in the same window cannot occur (one winner per window).
- Outputs are registered; no combinational path from inputs to outputs.
- A request deasserted before its load edge is simply not granted; no error.

Test Plan:
- Reset, then A write addr 0x00010 data 0xBEEF; next window A read 0x00010 -> OwAckA each at cnt==0, OwRValidA 8 cycles after the read ack, ObRDataA=0xBEEF; OwSramWrite high for exactly 5 cycles.
- Run the controller model at each of the 5 phase offsets relative to IwRstn release; repeat the write/read of 0x1FFFF/0x1234 -> correct data at every offset, exactly one SRAM write per write grant.
- A and B request continuously (reads) -> grant order A,A,A,A,B,A,A,A,A,B…; each port's rvalid data matches its own address pattern.
- Back-to-back A reads of 0x00001..0x00005 in consecutive windows -> five OwRValidA pulses 5 cycles apart, data in order.
- Only B requests (write 0x00020=0x5A5A, then read) -> B granted every window; rvalid B data 0x5A5A; A outputs stay 0.
- Assert IwRstn low for 1 cycle while an A read is in flight -> OwSramWrite=0 and all outputs 0 asynchronously; no OwRValidA for that read; the first request after reset is acked at the first cnt==0.
